rv32im_mau: RTL and testbench
=============================

Name: rv32im_mau

Overview:
Misaligned-access unit that sits directly downstream of the LSU and upstream of mem_RAM. It takes one sized load/store request at a time. Accesses that straddle a word boundary are split into two aligned word accesses; low and high halves are merged on loads and split on stores. Load results are returned zero- or sign-extended to 32 bits, and each request completes with a one-cycle response pulse.

Parameters:
SPLIT_EN, 1, 1 = split word-crossing accesses; 0 = word-crossing access returns rsp_err_o with no memory access

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  unit can accept request (high only in IDLE)
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, LSB-aligned
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  32  extended load data (0 for stores and errors)
rsp_err_o  out  1  valid with rsp_valid_o
mem_en_o  out  1  memory access strobe
mem_addr_o  out  32  word-aligned address (bits[1:0] = 0)
mem_wdata_o  out  32  lane-positioned write data
mem_wr_mask_o  out  4  byte write enables; 0 = read
mem_rdata_i  in  32  RAM read data, valid the cycle after the read is issued

Behaviour:
- Reset, asynchronous, any state: state goes to IDLE. All outputs are 0 except req_ready_o = 1. There is no rollback: a half-completed split store leaves its low word written.
- Acceptance: the request is latched at the rising edge where req_valid_i && req_ready_o. There is no response backpressure.
- Definitions: off = addr[1:0]; nb = 1/2/4 bytes for size 0/1/2; split = (off + nb > 4).
- Error cases: size 3, or split with SPLIT_EN = 0. Path is IDLE -> RESP with rsp_err_o = 1 and no mem_en_o.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
  - Aligned store: ISSUE0 -> RESP.
  - Aligned load: ISSUE0 -> WAIT0 -> RESP.
  - Split store: ISSUE0 -> ISSUE1 -> RESP.
  - Split load: ISSUE0 -> WAIT0 -> ISSUE1 -> WAIT1 -> RESP.
  - RESP -> IDLE always.
- Latency, counted from the acceptance edge to rsp_valid_o high:
  - Aligned store: 2 cycles.
  - Aligned load: 3 cycles.
  - Split store: 3 cycles.
  - Split load: 5 cycles.
- mem_en_o is high only in ISSUE0 and ISSUE1. mem outputs are 0 in every other state.
- ISSUE0: mem_addr_o = addr & ~3.
- ISSUE1: mem_addr_o = (addr & ~3) + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- Store lanes: W64 = {32'b0, wdata masked to nb bytes} << (8*off). ISSUE0 drives W64[31:0]; ISSUE1 drives W64[63:32].
- Write masks: M8 = ((1 << nb) - 1) << off. mem_wr_mask_o = M8[3:0] in ISSUE0 and M8[7:4] in ISSUE1. Loads drive mask 0.
- Load capture: mem_rdata_i is captured in WAIT0 as lo and in WAIT1 as hi; hi = 0 if not split.
- Load merge: R = {hi, lo} >> (8*off), truncated to nb bytes. The result is sign-extended from the top byte unless req_unsigned_i or nb = 4.
- rsp_rdata_o and rsp_err_o are held valid only during RESP and are 0 elsewhere.
- Request inputs are ignored outside IDLE.

Test Plan:
1. Preload mem[4] = 0xA1C2E394, mem[8] = 0xABCDEF89. Aligned LW at 0x4 -> one read of addr 0x4 with mask 0; rsp_valid_o 3 cycles after accept; rdata 0xA1C2E394; err 0.
2. Same preload, LH at 0x7 (signed) -> reads addr 0x4 then 0x8; rdata 0xFFFF89A1 after 5 cycles. LHU at 0x7 -> rdata 0x000089A1.
3. Same preload, LW at 0x6 -> rdata 0xEF89A1C2. LB at 0x5 -> 0xFFFFFFE3. LBU at 0x5 -> 0x000000E3.
4. SW 0x11223344 at 0x5 -> ISSUE0: addr 0x4, wdata 0x22334400, mask 1110. ISSUE1: addr 0x8, wdata 0x00000011, mask 0001. Follow-up LW 0x4 -> 0x22334494; LW 0x8 -> 0xABCDEF11.
5. SW at 0xFFFFFFFE -> second access addr 0x00000000, mask 0011. With SPLIT_EN = 0, LW at 0x2 -> rsp_err_o 1, rdata 0, mem_en_o never asserted. Size 3 request -> rsp_err_o 1.
6. reset_n low for one cycle during ISSUE1 of the split store in test 4 -> all outputs 0 immediately; req_ready_o 1 after release; mem[8] unchanged.

Source files
------------

// File: rtl/rv32im_mau.sv
// Misaligned-access unit between the LSU and a synchronous word RAM.
// Word-crossing accesses become two aligned word accesses; loads are merged and extended.
module rv32im_mau #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wr_mask_o,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

    state_t      state;
    logic [29:0] addr_w_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic        split_q;
    logic [31:0] whi_q;
    logic [3:0]  mhi_q;
    logic [31:0] lo_q;

    logic [1:0]  off_c;
    logic [2:0]  nb_c;
    logic [3:0]  bmask_c;
    logic [31:0] wd_c;
    logic [63:0] w64_c;
    logic [7:0]  m8_c;
    logic        split_c;
    logic        err_c;

    // Shift the {hi,lo} pair down to the addressed byte and extend to 32 bits.
    function automatic logic [31:0] merge(input logic [63:0] d, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = 32'(d >> {off, 3'b000});
        case (size)
            2'd0:    merge = {{24{sh[7] & ~uns}}, sh[7:0]};
            2'd1:    merge = {{16{sh[15] & ~uns}}, sh[15:0]};
            default: merge = sh;
        endcase
    endfunction

    // Lane placement of the incoming request, evaluated at acceptance.
    always_comb begin
        off_c = req_addr_i[1:0];
        case (req_size_i)
            2'd0: begin
                nb_c    = 3'd1;
                bmask_c = 4'b0001;
                wd_c    = {24'b0, req_wdata_i[7:0]};
            end
            2'd1: begin
                nb_c    = 3'd2;
                bmask_c = 4'b0011;
                wd_c    = {16'b0, req_wdata_i[15:0]};
            end
            default: begin
                nb_c    = 3'd4;
                bmask_c = 4'b1111;
                wd_c    = req_wdata_i;
            end
        endcase
        w64_c   = {32'b0, wd_c} << {off_c, 3'b000};
        m8_c    = {4'b0, bmask_c} << off_c;
        split_c = (4'(off_c) + 4'(nb_c)) > 4'd4;
        err_c   = (req_size_i == 2'd3) || (split_c && !SPLIT_EN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            mem_en_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            mem_wr_mask_o <= '0;
            addr_w_q      <= '0;
            off_q         <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            we_q          <= 1'b0;
            split_q       <= 1'b0;
            whi_q         <= '0;
            mhi_q         <= '0;
            lo_q          <= '0;
        end else begin
            // Outputs are registered alongside the state they belong to.
            req_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            mem_en_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            mem_wr_mask_o <= '0;
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        addr_w_q    <= req_addr_i[31:2];
                        off_q       <= off_c;
                        size_q      <= req_size_i;
                        uns_q       <= req_unsigned_i;
                        we_q        <= req_we_i;
                        split_q     <= split_c;
                        whi_q       <= w64_c[63:32];
                        mhi_q       <= m8_c[7:4];
                        if (err_c) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            state         <= ISSUE0;
                            mem_en_o      <= 1'b1;
                            mem_addr_o    <= {req_addr_i[31:2], 2'b00};
                            mem_wdata_o   <= req_we_i ? w64_c[31:0] : '0;
                            mem_wr_mask_o <= req_we_i ? m8_c[3:0] : '0;
                        end
                    end
                end
                ISSUE0: begin
                    if (!we_q) begin
                        state <= WAIT0;
                    end else if (split_q) begin
                        state         <= ISSUE1;
                        mem_en_o      <= 1'b1;
                        mem_addr_o    <= {addr_w_q + 30'd1, 2'b00};
                        mem_wdata_o   <= whi_q;
                        mem_wr_mask_o <= mhi_q;
                    end else begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                    end
                end
                WAIT0: begin
                    lo_q <= mem_rdata_i;
                    if (split_q) begin
                        state      <= ISSUE1;
                        mem_en_o   <= 1'b1;
                        mem_addr_o <= {addr_w_q + 30'd1, 2'b00};
                    end else begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= merge({32'b0, mem_rdata_i}, off_q, size_q, uns_q);
                    end
                end
                ISSUE1: begin
                    if (we_q) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                    end else begin
                        state <= WAIT1;
                    end
                end
                WAIT1: begin
                    state       <= RESP;
                    rsp_valid_o <= 1'b1;
                    rsp_rdata_o <= merge({mem_rdata_i, lo_q}, off_q, size_q, uns_q);
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32im_mau.sv
// Directed bench for rv32im_mau: a split-enabled unit on a small word RAM model
// plus a split-disabled unit for the error path.
module tb_rv32im_mau;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        preload = 1'b1;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;

    logic        ready0, rsp_valid0, err0, en0;
    logic [31:0] rdata0, maddr0, mwdata0, mrdata0;
    logic [3:0]  mask0;
    logic        ready1, rsp_valid1, err1, en1;
    logic [31:0] rdata1, maddr1, mwdata1;
    logic [31:0] mrdata1 = '0;
    logic [3:0]  mask1;

    logic [31:0] mem [16];
    logic [31:0] log_addr [$];
    logic [31:0] log_wd [$];
    logic [31:0] log_mask [$];
    int          en1_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rv32im_mau #(.SPLIT_EN(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid_i(valid0), .req_ready_o(ready0),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid0),
        .rsp_rdata_o(rdata0), .rsp_err_o(err0), .mem_en_o(en0), .mem_addr_o(maddr0),
        .mem_wdata_o(mwdata0), .mem_wr_mask_o(mask0), .mem_rdata_i(mrdata0)
    );

    rv32im_mau #(.SPLIT_EN(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid_i(valid1), .req_ready_o(ready1),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid1),
        .rsp_rdata_o(rdata1), .rsp_err_o(err1), .mem_en_o(en1), .mem_addr_o(maddr1),
        .mem_wdata_o(mwdata1), .mem_wr_mask_o(mask1), .mem_rdata_i(mrdata1)
    );

    // Synchronous RAM: read data is valid the cycle after the read is issued.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[1] <= 32'hA1C2E394;
            mem[2] <= 32'hABCDEF89;
        end else if (en0) begin
            log_addr.push_back(maddr0);
            log_wd.push_back(mwdata0);
            log_mask.push_back({28'b0, mask0});
            if (mask0 == 4'b0000) begin
                mrdata0 <= mem[maddr0[5:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mask0[b]) mem[maddr0[5:2]][8*b +: 8] <= mwdata0[8*b +: 8];
            end
        end
    end

    always @(posedge clk) if (en1) en1_cnt <= en1_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request; lat counts cycles from the acceptance edge to rsp_valid.
    task automatic do_req(input bit inst, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        bit seen;
        @(negedge clk);
        log_addr.delete(); log_wd.delete(); log_mask.delete();
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        chk("ready_before", {31'b0, inst ? ready1 : ready0}, 32'd1);
        if (inst) valid1 = 1'b1; else valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0; valid1 = 1'b0;
        lat = 1;
        seen = inst ? rsp_valid1 : rsp_valid0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            seen = inst ? rsp_valid1 : rsp_valid0;
        end
        if (!seen) chk("rsp_timeout", 32'd0, 32'd1);
        rdata = inst ? rdata1 : rdata0;
        err   = inst ? err1 : err0;
        @(posedge clk);
        #1;
        chk("rsp_pulse", {31'b0, inst ? rsp_valid1 : rsp_valid0}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready0}, 32'd1);
        chk("rst_outs", {rsp_valid0, err0, en0, mask0}, 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_maddr", maddr0 | mwdata0, 32'd0);
        @(negedge clk);
        preload = 1'b0;
        reset_n = 1'b1;

        // Aligned word load
        do_req(0, 0, 2'd2, 0, 32'h4, 32'h0, rd, er, lat);
        chk("lw4_rdata", rd, 32'hA1C2E394);
        chk("lw4_err", {31'b0, er}, 32'd0);
        chk("lw4_lat", 32'(lat), 32'd3);
        chk("lw4_nacc", 32'(log_addr.size()), 32'd1);
        chk("lw4_addr", log_addr[0], 32'h4);
        chk("lw4_mask", log_mask[0], 32'h0);

        // Split half loads
        do_req(0, 0, 2'd1, 0, 32'h7, 32'h0, rd, er, lat);
        chk("lh7_rdata", rd, 32'hFFFF89A1);
        chk("lh7_lat", 32'(lat), 32'd5);
        chk("lh7_nacc", 32'(log_addr.size()), 32'd2);
        chk("lh7_addr0", log_addr[0], 32'h4);
        chk("lh7_addr1", log_addr[1], 32'h8);
        do_req(0, 0, 2'd1, 1, 32'h7, 32'h0, rd, er, lat);
        chk("lhu7_rdata", rd, 32'h000089A1);

        // Split word load and aligned byte loads
        do_req(0, 0, 2'd2, 0, 32'h6, 32'h0, rd, er, lat);
        chk("lw6_rdata", rd, 32'hEF89A1C2);
        do_req(0, 0, 2'd0, 0, 32'h5, 32'h0, rd, er, lat);
        chk("lb5_rdata", rd, 32'hFFFFFFE3);
        chk("lb5_lat", 32'(lat), 32'd3);
        do_req(0, 0, 2'd0, 1, 32'h5, 32'h0, rd, er, lat);
        chk("lbu5_rdata", rd, 32'h000000E3);

        // Split word store
        do_req(0, 1, 2'd2, 0, 32'h5, 32'h11223344, rd, er, lat);
        chk("sw5_lat", 32'(lat), 32'd3);
        chk("sw5_rdata", rd, 32'h0);
        chk("sw5_nacc", 32'(log_addr.size()), 32'd2);
        chk("sw5_addr0", log_addr[0], 32'h4);
        chk("sw5_wd0", log_wd[0], 32'h22334400);
        chk("sw5_mask0", log_mask[0], 32'hE);
        chk("sw5_addr1", log_addr[1], 32'h8);
        chk("sw5_wd1", log_wd[1], 32'h00000011);
        chk("sw5_mask1", log_mask[1], 32'h1);
        do_req(0, 0, 2'd2, 0, 32'h4, 32'h0, rd, er, lat);
        chk("sw5_lw4", rd, 32'h22334494);
        do_req(0, 0, 2'd2, 0, 32'h8, 32'h0, rd, er, lat);
        chk("sw5_lw8", rd, 32'hABCDEF11);

        // Aligned half store
        do_req(0, 1, 2'd1, 0, 32'h2, 32'h1234BEEF, rd, er, lat);
        chk("sh2_lat", 32'(lat), 32'd2);
        chk("sh2_wd", log_wd[0], 32'hBEEF0000);
        chk("sh2_mask", log_mask[0], 32'hC);

        // Address wrap on the second access
        do_req(0, 1, 2'd2, 0, 32'hFFFFFFFE, 32'hAABBCCDD, rd, er, lat);
        chk("wrap_addr0", log_addr[0], 32'hFFFFFFFC);
        chk("wrap_wd0", log_wd[0], 32'hCCDD0000);
        chk("wrap_mask0", log_mask[0], 32'hC);
        chk("wrap_addr1", log_addr[1], 32'h0);
        chk("wrap_wd1", log_wd[1], 32'h0000AABB);
        chk("wrap_mask1", log_mask[1], 32'h3);

        // Error paths
        do_req(1, 0, 2'd2, 0, 32'h2, 32'h0, rd, er, lat);
        chk("nosplit_err", {31'b0, er}, 32'd1);
        chk("nosplit_rdata", rd, 32'h0);
        chk("nosplit_lat", 32'(lat), 32'd1);
        chk("nosplit_en", 32'(en1_cnt), 32'd0);
        do_req(0, 0, 2'd3, 0, 32'h4, 32'h0, rd, er, lat);
        chk("size3_err", {31'b0, er}, 32'd1);
        chk("size3_nacc", 32'(log_addr.size()), 32'd0);

        // Reset in the middle of a split store keeps only the low word
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h5; req_wdata = 32'h55667788;
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_iss1_addr", maddr0, 32'h8);
        chk("rst_iss1_mask", {28'b0, mask0}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_en", {31'b0, en0}, 32'd0);
        chk("rst_async_mem", maddr0 | mwdata0 | {28'b0, mask0}, 32'd0);
        chk("rst_async_rsp", {rsp_valid0, err0} | rdata0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_rel_ready", {31'b0, ready0}, 32'd1);
        @(posedge clk);
        #1;
        chk("rst_mem4", mem[1], 32'h66778894);
        chk("rst_mem8", mem[2], 32'hABCDEF11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
